// File: rtl/step_rx_pkg.sv
// Shared types and defaults for the STEP/DIR receive path (step_pulse_counter).
package step_rx_pkg;

  localparam int POS_W                  = 32;
  localparam int DEFAULT_FILTER_LEN     = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_DONE     = 2'd2
  } rx_state_e;

  function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
    return (v == '1) ? v : v + POS_W'(1);
  endfunction

endpackage

// File: rtl/step_input_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output follows the
// synchronized input only after it has held a new value for FILTER_LEN cycles.
module step_input_filter
  import step_rx_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             filt_q,  filt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sync1_d = din;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_MAX) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/step_pulse_counter.sv
// STEP/DIR receiver: position, armed step count, idle timeout, and an optional
// step-period measurement enabled by defining STEP_RX_PERIOD_EN.
module step_pulse_counter
  import step_rx_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_in,
  input  logic              dir_in,
  input  logic              clear,
  input  logic              arm,
  input  logic [POS_W-1:0]  target,
  output logic [POS_W-1:0]  position,
  output logic [POS_W-1:0]  step_count,
  output logic              step_strobe,
  output logic              done,
  output logic              idle,
  output logic [POS_W-1:0]  period,
  output logic              period_valid
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES);

  logic step_f;
  logic dir_f;
  logic rise;
  logic accept;

  step_input_filter #(.FILTER_LEN(FILTER_LEN)) u_step_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (step_in),
    .dout (step_f)
  );

  step_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dir_filter (
    .clk  (clk),
    .rst  (rst),
    .din  (dir_in),
    .dout (dir_f)
  );

  rx_state_e          state_q,     state_d;
  logic [POS_W-1:0]   target_q,    target_d;
  logic [POS_W-1:0]   position_q,  position_d;
  logic [POS_W-1:0]   count_q,     count_d;
  logic               strobe_q,    strobe_d;
  logic               step_prev_q, step_prev_d;
  logic [TIMER_W-1:0] timer_q,     timer_d;
  logic [POS_W-1:0]   count_inc;

  // A step coincident with clear is dropped entirely.
  assign rise      = step_f & ~step_prev_q;
  assign accept    = rise & ~clear;
  assign count_inc = sat_inc(count_q);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    position_d  = position_q;
    count_d     = count_q;
    step_prev_d = step_f;
    strobe_d    = accept;
    timer_d     = timer_q;

    if (accept) begin
      position_d = dir_f ? position_q + POS_W'(1) : position_q - POS_W'(1);
    end

    unique case (state_q)
      ST_IDLE: ;
      ST_COUNTING: begin
        if (accept) begin
          count_d = count_inc;
          if (count_inc == target_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (accept) begin
          count_d = count_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Arm restarts the count but still counts a coincident step.
    if (arm) begin
      target_d = target;
      count_d  = rise ? POS_W'(1) : '0;
      state_d  = (target == count_d) ? ST_DONE : ST_COUNTING;
    end

    if (clear) begin
      state_d    = ST_IDLE;
      position_d = '0;
      count_d    = '0;
    end

    if (accept) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // NOTE: reset is synchronous and active-high, sampled only on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      target_q    <= '0;
      position_q  <= '0;
      count_q     <= '0;
      strobe_q    <= 1'b0;
      step_prev_q <= 1'b0;
      timer_q     <= TIMER_MAX;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      position_q  <= position_d;
      count_q     <= count_d;
      strobe_q    <= strobe_d;
      step_prev_q <= step_prev_d;
      timer_q     <= timer_d;
    end
  end

  assign position    = position_q;
  assign step_count  = count_q;
  assign step_strobe = strobe_q;
  assign done        = (state_q == ST_DONE);
  assign idle        = (timer_q == TIMER_MAX);

`ifdef STEP_RX_PERIOD_EN
  logic [POS_W-1:0] per_cnt_q, per_cnt_d;
  logic [POS_W-1:0] period_q,  period_d;
  logic             seen_q,    seen_d;
  logic             valid_q,   valid_d;

  always_comb begin
    per_cnt_d = sat_inc(per_cnt_q);
    period_d  = period_q;
    seen_d    = seen_q;
    valid_d   = valid_q;
    if (accept) begin
      period_d  = sat_inc(per_cnt_q);
      per_cnt_d = '0;
      seen_d    = 1'b1;
      valid_d   = seen_q;
    end
    if (clear) begin
      per_cnt_d = '0;
      period_d  = '0;
      seen_d    = 1'b0;
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_q <= '0;
      period_q  <= '0;
      seen_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      seen_q    <= seen_d;
      valid_q   <= valid_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule
